// File: rtl/sha1_pkg.sv
// Shared constants, FSM state type and block-layout helper for the SHA-1 padder.
package sha1_pkg;

  localparam int SHA1_BLK_W = 512;
  localparam int SHA1_WORDS = 16;
  localparam logic [31:0] SHA1_PAD_WORD = 32'h80000000;
  localparam logic [7:0] SHA1_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    COLLECT,
    PAD,
    EMIT
  } state_t;

  // Bit offset of the LSB of word i inside a block; word 0 sits at the top.
  function automatic int blk_word_lsb(input int i);
    return SHA1_BLK_W - 32 * (i + 1);
  endfunction

endpackage

// File: rtl/sha1_pad_merge.sv
// Combinational merge of a message word: masks bytes past the end of a short
// last word, inserts the 0x80 marker byte and reports the bit-length increment.
module sha1_pad_merge
  import sha1_pkg::*;
(
  input  logic [31:0] in_data,
  input  logic [1:0]  in_bytes,
  input  logic        in_last,
  output logic [31:0] word,
  output logic        marker_done,
  output logic [5:0]  len_incr
);

  // A full last word (in_bytes == 0) leaves the marker to the padding phase.
  always_comb begin
    word        = in_data;
    marker_done = 1'b0;
    len_incr    = 6'd32;
    if (in_last) begin
      case (in_bytes)
        2'd1: begin
          word        = {in_data[31:24], SHA1_PAD_BYTE, 16'h0000};
          marker_done = 1'b1;
          len_incr    = 6'd8;
        end
        2'd2: begin
          word        = {in_data[31:16], SHA1_PAD_BYTE, 8'h00};
          marker_done = 1'b1;
          len_incr    = 6'd16;
        end
        2'd3: begin
          word        = {in_data[31:8], SHA1_PAD_BYTE};
          marker_done = 1'b1;
          len_incr    = 6'd24;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sha1_padder.sv
// SHA-1 message padder: collects 32-bit words into a 16-word block, appends
// the marker, zero fill and 64-bit length, and hands out 512-bit blocks.
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic                  in_last,
  input  logic [1:0]            in_bytes,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [SHA1_BLK_W-1:0] blk_data,
  output logic                  blk_first,
  output logic                  blk_final
);

  state_t           state;
  logic [3:0]       widx;
  logic [31:0]      words [SHA1_WORDS];
  logic [LEN_W-1:0] bit_len;
  logic             marker_done;
  logic             spill;          // marker sits at word 14/15: length goes to a second block
  logic             pad_pending;    // a further padding block follows the current one
  logic             first_pending;

  logic [31:0] m_word;
  logic        m_marker;
  logic [5:0]  m_incr;
  logic        in_fire;
  logic        pad_final;

  sha1_pad_merge u_merge (
    .in_data     (in_data),
    .in_bytes    (in_bytes),
    .in_last     (in_last),
    .word        (m_word),
    .marker_done (m_marker),
    .len_incr    (m_incr)
  );

  assign in_ready  = (state == COLLECT);
  assign in_fire   = in_valid & in_ready;
  // Reaching word 15 with the marker already placed and no spill means the
  // length words were written into this block.
  assign pad_final = marker_done & ~spill;

  // Flatten the word buffer onto the block bus, word 0 in the top bits.
  generate
    for (genvar gi = 0; gi < SHA1_WORDS; gi++) begin : g_pack
      assign blk_data[blk_word_lsb(gi) +: 32] = words[gi];
    end
  endgenerate

  // Control FSM, word buffer and bit-length counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= COLLECT;
      widx          <= '0;
      bit_len       <= '0;
      marker_done   <= 1'b0;
      spill         <= 1'b0;
      pad_pending   <= 1'b0;
      first_pending <= 1'b1;
      blk_valid     <= 1'b0;
      blk_first     <= 1'b0;
      blk_final     <= 1'b0;
      for (int i = 0; i < SHA1_WORDS; i++) words[i] <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_fire) begin
            words[widx] <= m_word;
            widx        <= widx + 4'd1;
            bit_len     <= bit_len + LEN_W'(m_incr);
            marker_done <= m_marker;
            spill       <= m_marker && (widx >= 4'd14);
            if (widx == 4'd15) begin
              // Block full: ship it; a last word here means padding continues
              // in a fresh block.
              state       <= EMIT;
              blk_valid   <= 1'b1;
              blk_first   <= first_pending;
              blk_final   <= 1'b0;
              pad_pending <= in_last;
            end else if (in_last) begin
              state <= PAD;
            end
          end
        end

        PAD: begin
          widx <= widx + 4'd1;
          if (!marker_done) begin
            words[widx] <= SHA1_PAD_WORD;
            marker_done <= 1'b1;
            spill       <= (widx >= 4'd14);
          end else if (spill) begin
            words[widx] <= '0;
          end else if (widx == 4'd14) begin
            words[widx] <= bit_len[63:32];
          end else if (widx == 4'd15) begin
            words[widx] <= bit_len[31:0];
          end else begin
            words[widx] <= '0;
          end
          if (widx == 4'd15) begin
            state       <= EMIT;
            blk_valid   <= 1'b1;
            blk_first   <= first_pending;
            blk_final   <= pad_final;
            pad_pending <= ~pad_final;
          end
        end

        EMIT: begin
          if (blk_ready) begin
            for (int i = 0; i < SHA1_WORDS; i++) words[i] <= '0;
            widx          <= '0;
            spill         <= 1'b0;
            blk_valid     <= 1'b0;
            blk_first     <= 1'b0;
            blk_final     <= 1'b0;
            first_pending <= 1'b0;
            if (pad_pending) begin
              state       <= PAD;
              pad_pending <= 1'b0;
            end else if (blk_final) begin
              state         <= COLLECT;
              bit_len       <= '0;
              marker_done   <= 1'b0;
              first_pending <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

endmodule
